// File: rtl/gsr_release_seq.sv
// rtl/gsr_release_seq.sv - global set/reset and power-up reset release sequencer
//
// Purpose: drives active-low PURN and per-domain GSRN for the cell library's
// GSR/PUR nets. Runs the power-up sequence after reset, debounces REQ into
// GSR assertions, and releases the domains after a programmable hold.
//
// Optional feature macro: GSR_RELEASE_STAGGER_EN (staggered domain release,
// GSRN[i] rises STAGGER_CYCLES*i cycles after GSRN[0]).
//
// Ports:
//   CK       in   rising-edge clock
//   CD       in   synchronous active-high reset
//   REQ      in   GSR request, level-sampled on CK
//   GSRN     out  [N_DOM] active-low global set/reset, one bit per domain
//   PURN     out  active-low power-up reset
//   BUSY     out  any GSRN/PURN low, or a debounce in progress
//   DONE     out  one-cycle pulse when the last GSRN bit rises
//   EVT_CNT  out  [8] completed request-triggered assertions, saturating
module gsr_release_seq #(
  parameter int N_DOM           = 4,
  parameter int PUR_CYCLES      = 8,
  parameter int ASSERT_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int STAGGER_CYCLES  = 2
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             REQ,
  output logic [N_DOM-1:0] GSRN,
  output logic             PURN,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       EVT_CNT
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(PUR_CYCLES, ASSERT_CYCLES),
                                max2(DEBOUNCE_CYCLES, STAGGER_CYCLES * N_DOM));
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    ST_PUR_HOLD,
    ST_GSR_HOLD,
    ST_RELEASE,
    ST_IDLE,
    ST_DEBOUNCE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [N_DOM-1:0] r_gsrn;
  logic             r_purn;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_evt;

  state_t           w_state_next;
  logic [CW-1:0]    w_cnt_next;
  logic [CW-1:0]    w_cnt_inc;
  logic [N_DOM-1:0] w_gsrn_next;
  logic             w_purn_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic [7:0]       w_evt_next;
  logic [7:0]       w_evt_sat;

  assign w_evt_sat = (r_evt == 8'hFF) ? r_evt : r_evt + 8'd1;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_gsrn_next  = r_gsrn;
    w_purn_next  = r_purn;
    w_done_next  = 1'b0;
    w_evt_next   = r_evt;
    w_cnt_inc    = r_cnt + CW'(1);

    case (r_state)
      ST_PUR_HOLD: begin
        w_purn_next = 1'b0;
        w_gsrn_next = '0;
        if (r_cnt == CW'(PUR_CYCLES - 1)) begin
          w_state_next = ST_GSR_HOLD;
          w_cnt_next   = '0;
          w_purn_next  = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      ST_GSR_HOLD: begin
        w_gsrn_next = '0;
        // A request during the hold stretches it rather than queueing another.
        if (REQ) begin
          w_cnt_next = '0;
        end else if (r_cnt == CW'(ASSERT_CYCLES - 1)) begin
          w_state_next = ST_RELEASE;
          w_cnt_next   = '0;
`ifdef GSR_RELEASE_STAGGER_EN
          w_gsrn_next[0] = 1'b1;
          w_done_next    = (N_DOM == 1);
`else
          w_gsrn_next = '1;
          w_done_next = 1'b1;
`endif
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      ST_RELEASE: begin
        if (REQ) begin
          // Reassert everything, including domains already released.
          w_state_next = ST_GSR_HOLD;
          w_cnt_next   = '0;
          w_gsrn_next  = '0;
        end else if (&r_gsrn) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
`ifdef GSR_RELEASE_STAGGER_EN
          // r_cnt counts release cycles; domain i opens once it reaches STAGGER_CYCLES*i.
          w_cnt_next = w_cnt_inc;
          for (int i = 0; i < N_DOM; i++) begin
            if (CW'(STAGGER_CYCLES * i) <= w_cnt_inc) begin
              w_gsrn_next[i] = 1'b1;
            end
          end
          w_done_next = (w_cnt_inc == CW'(STAGGER_CYCLES * (N_DOM - 1)));
`else
          w_gsrn_next = '1;
`endif
        end
      end

      ST_IDLE: begin
        if (REQ) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_next = ST_GSR_HOLD;
            w_cnt_next   = '0;
            w_gsrn_next  = '0;
            w_evt_next   = w_evt_sat;
          end else begin
            w_state_next = ST_DEBOUNCE;
            w_cnt_next   = CW'(1);
          end
        end
      end

      ST_DEBOUNCE: begin
        if (!REQ) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state_next = ST_GSR_HOLD;
          w_cnt_next   = '0;
          w_gsrn_next  = '0;
          w_evt_next   = w_evt_sat;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      default: begin
        w_state_next = ST_PUR_HOLD;
        w_cnt_next   = '0;
        w_purn_next  = 1'b0;
        w_gsrn_next  = '0;
      end
    endcase

    w_busy_next = ~(&w_gsrn_next) | ~w_purn_next | (w_state_next == ST_DEBOUNCE);
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      r_state <= ST_PUR_HOLD;
      r_cnt   <= '0;
      r_gsrn  <= '0;
      r_purn  <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_evt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_gsrn  <= w_gsrn_next;
      r_purn  <= w_purn_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_evt   <= w_evt_next;
    end
  end

  assign GSRN    = r_gsrn;
  assign PURN    = r_purn;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign EVT_CNT = r_evt;

endmodule

// File: tb/tb_gsr_release_seq.sv
// tb/tb_gsr_release_seq.sv - self-checking bench for gsr_release_seq
module tb_gsr_release_seq;

  localparam int N_DOM   = 4;
  localparam int PUR     = 8;
  localparam int ASSERTC = 16;
  localparam int DEB     = 3;
  localparam int STAGGER = 2;
`ifdef GSR_RELEASE_STAGGER_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif
  localparam int LAST = STAG ? STAGGER * (N_DOM - 1) : 0;

  logic             CK;
  logic             CD;
  logic             REQ;
  logic [N_DOM-1:0] GSRN;
  logic             PURN;
  logic             BUSY;
  logic             DONE;
  logic [7:0]       EVT_CNT;

  gsr_release_seq #(
    .N_DOM          (N_DOM),
    .PUR_CYCLES     (PUR),
    .ASSERT_CYCLES  (ASSERTC),
    .DEBOUNCE_CYCLES(DEB),
    .STAGGER_CYCLES (STAGGER)
  ) dut (
    .CK     (CK),
    .CD     (CD),
    .REQ    (REQ),
    .GSRN   (GSRN),
    .PURN   (PURN),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .EVT_CNT(EVT_CNT)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: remaining-cycle timers and release age, not states.
  int m_pur_left  = PUR;
  int m_hold_left = 0;
  int m_rel_age   = -1;
  int m_streak    = 0;
  int m_evt       = 0;
  bit m_done      = 1'b0;

  task automatic model_step(input bit cd, input bit req);
    if (cd) begin
      m_pur_left  = PUR;
      m_hold_left = 0;
      m_rel_age   = -1;
      m_streak    = 0;
      m_evt       = 0;
    end else if (m_pur_left > 0) begin
      m_pur_left--;
      if (m_pur_left == 0) m_hold_left = ASSERTC;
    end else if (m_hold_left > 0) begin
      if (req) m_hold_left = ASSERTC;
      else begin
        m_hold_left--;
        if (m_hold_left == 0) m_rel_age = 0;
      end
    end else if (m_rel_age >= 0) begin
      if (req) begin
        m_rel_age   = -1;
        m_hold_left = ASSERTC;
      end else if (m_rel_age >= LAST) m_rel_age = -1;
      else m_rel_age++;
    end else if (req) begin
      m_streak++;
      if (m_streak >= DEB) begin
        m_streak    = 0;
        m_hold_left = ASSERTC;
        if (m_evt < 255) m_evt++;
      end
    end else begin
      m_streak = 0;
    end
    m_done = !cd && (m_rel_age == LAST) && (m_hold_left == 0);
  endtask

  function automatic logic [N_DOM-1:0] exp_gsrn();
    logic [N_DOM-1:0] g;
    g = '1;
    if (m_pur_left > 0 || m_hold_left > 0) g = '0;
    else if (m_rel_age >= 0) begin
      for (int i = 0; i < N_DOM; i++) g[i] = STAG ? (m_rel_age >= STAGGER * i) : 1'b1;
    end
    return g;
  endfunction

  int zero_ticks = 0;
  int edge_no    = 0;

  task automatic tick(input bit cd, input bit req);
    logic [N_DOM-1:0] g;
    CD  = cd;
    REQ = req;
    @(posedge CK);
    model_step(cd, req);
    #1;
    edge_no++;
    g = exp_gsrn();
    check_eq("GSRN", 32'(GSRN), 32'(g));
    check_eq("PURN", 32'(PURN), 32'(m_pur_left == 0));
    check_eq("BUSY", 32'(BUSY), 32'((g != '1) || (m_pur_left > 0) || (m_streak > 0)));
    check_eq("DONE", 32'(DONE), 32'(m_done));
    check_eq("EVT_CNT", 32'(EVT_CNT), 32'(m_evt));
    if (GSRN == '0) zero_ticks++;
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
  endtask

  initial begin
    int done_edge;
    int dens;
    bit cd_r;
    bit req_r;
    CD  = 1'b1;
    REQ = 1'b0;

    // Power-up
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0);
    edge_no   = 0;
    done_edge = -1;
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 1'b0);
      if (DONE && done_edge < 0) done_edge = edge_no;
    end
    check_eq("pwrup_done_edge", 32'(done_edge), 32'(PUR + ASSERTC + LAST));

    // Glitch rejection: two high samples only
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    idle_ticks(4);
    check_eq("glitch_evt", 32'(EVT_CNT), 32'd0);

    // Valid request
    for (int k = 0; k < DEB; k++) tick(1'b0, 1'b1);
    check_eq("valid_gsrn_low", 32'(GSRN), 32'd0);
    idle_ticks(30);
    check_eq("valid_evt", 32'(EVT_CNT), 32'd1);

    // Extension: second pulse in hold cycle 10
    zero_ticks = 0;
    for (int k = 0; k < DEB; k++) tick(1'b0, 1'b1);
    idle_ticks(9);
    tick(1'b0, 1'b1);
    idle_ticks(30);
    check_eq("ext_low_cycles", 32'(zero_ticks), 32'(ASSERTC + 10));
    check_eq("ext_evt", 32'(EVT_CNT), 32'd2);

    // Mid-sequence reset during hold
    for (int k = 0; k < DEB; k++) tick(1'b0, 1'b1);
    idle_ticks(5);
    tick(1'b1, 1'b0);
    check_eq("midrst_evt", 32'(EVT_CNT), 32'd0);
    check_eq("midrst_purn", 32'(PURN), 32'd0);
    idle_ticks(40);

    // Request during release
    for (int k = 0; k < DEB; k++) tick(1'b0, 1'b1);
    idle_ticks(ASSERTC + LAST / 2);
    tick(1'b0, 1'b1);
    check_eq("rel_req_gsrn", 32'(GSRN), 32'd0);
    idle_ticks(30);

    // Saturation of EVT_CNT
    for (int p = 0; p < 260; p++) begin
      for (int k = 0; k < DEB; k++) tick(1'b0, 1'b1);
      idle_ticks(ASSERTC + LAST + 3);
    end
    check_eq("evt_saturate", 32'(EVT_CNT), 32'd255);

    // Randomized traffic
    dens = 0;
    for (int k = 0; k < 2000; k++) begin
      if (k % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 0;
          1: dens = 15;
          2: dens = 50;
          default: dens = 90;
        endcase
      end
      cd_r  = ($urandom_range(0, 299) == 0);
      req_r = ($urandom_range(0, 99) < dens);
      tick(cd_r, req_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
